// File: rtl/pad_scan_pkg.sv
// Shared constants and types for the Genesis DB9 pad scanner.
package pad_scan_pkg;
  localparam int NUM_PHASES = 8;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  typedef enum logic [1:0] {IDLE, STEP, GAP} state_e;
endpackage

// File: rtl/pad_scan_decode.sv
// Combinational decode of one pad's eight inverted TH-phase samples into buttons/presence/type.
module pad_scan_decode
  import pad_scan_pkg::*;
(
  input  logic [NUM_PHASES-1:0][5:0] samp_i,
  output logic [11:0]                btn_o,
  output logic                       present_o,
  output logic                       six_o
);
  logic [11:0] raw;
  logic        unused_samp;

  // Phases 2,3,4,7 and the fixed-level pins carry no button information.
  assign unused_samp = ^{samp_i[2], samp_i[3], samp_i[4], samp_i[7],
                         samp_i[1][1:0], samp_i[5][5:4], samp_i[6][5:4]};

  always_comb begin
    raw            = '0;
    present_o      = samp_i[1][3] & samp_i[1][2];
    six_o          = present_o & (samp_i[5][3:0] == 4'hF);
    raw[BTN_UP]    = samp_i[0][0];
    raw[BTN_DOWN]  = samp_i[0][1];
    raw[BTN_LEFT]  = samp_i[0][2];
    raw[BTN_RIGHT] = samp_i[0][3];
    raw[BTN_B]     = samp_i[0][4];
    raw[BTN_C]     = samp_i[0][5];
    raw[BTN_A]     = samp_i[1][4];
    raw[BTN_START] = samp_i[1][5];
    if (six_o) begin
      raw[BTN_Z]    = samp_i[6][0];
      raw[BTN_Y]    = samp_i[6][1];
      raw[BTN_X]    = samp_i[6][2];
      raw[BTN_MODE] = samp_i[6][3];
    end
    btn_o = present_o ? raw : 12'h000;
  end
endmodule

// File: rtl/pad_scan_ctrl.sv
// Genesis DB9 multi-pad TH-handshake scanner with per-pad button decode.
// Optional macro PAD_SCAN_DEBOUNCE_EN: BTN only follows two identical consecutive decodes.
module pad_scan_ctrl
  import pad_scan_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int STEP_CYC = 8,
  parameter int IDLE_CYC = 2048
)(
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     CE,
  input  logic                     SCAN_REQ,
  input  logic [5:0]               PAD_D,
  output logic                     PAD_TH,
  output logic [2:0]               PAD_IDX,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [12*NUM_PADS-1:0]   BTN,
  output logic [NUM_PADS-1:0]      PRESENT,
  output logic [NUM_PADS-1:0]      SIX_BTN
);
  localparam int CNT_MAX = (IDLE_CYC > STEP_CYC) ? IDLE_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STEP_LD  = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(IDLE_CYC - 1);
  localparam logic [2:0]       LAST_PAD = 3'(NUM_PADS - 1);
  localparam logic [2:0]       LAST_PH  = 3'(NUM_PHASES - 1);

  state_e                            state_q, state_d;
  logic [5:0]                        meta_q, sync_q;
  logic                              th_q, th_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]                        idx_q, idx_d, phase_q, phase_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_PHASES-1:0][5:0]        samp_q, samp_d, dec_samp;
  logic [NUM_PADS-1:0][11:0]         btn_q, btn_d;
  logic [NUM_PADS-1:0]               pres_q, pres_d, six_q, six_d;
  logic [11:0]                       dec_btn;
  logic                              dec_pres, dec_six;
`ifdef PAD_SCAN_DEBOUNCE_EN
  logic [NUM_PADS-1:0][11:0]         prev_q, prev_d;
`endif

  // Pins are asynchronous to CLK; the synchronizer ignores CE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q <= 6'h3F;
      sync_q <= 6'h3F;
    end else begin
      meta_q <= PAD_D;
      sync_q <= meta_q;
    end
  end

  // Phase 7 is sampled on the commit edge itself, so feed it straight from the synchronizer.
  always_comb begin
    dec_samp                 = samp_q;
    dec_samp[NUM_PHASES-1]   = ~sync_q;
  end

  pad_scan_decode u_dec (
    .samp_i    (dec_samp),
    .btn_o     (dec_btn),
    .present_o (dec_pres),
    .six_o     (dec_six)
  );

  always_comb begin
    state_d = state_q;
    th_d    = th_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    samp_d  = samp_q;
    btn_d   = btn_q;
    pres_d  = pres_q;
    six_d   = six_q;
`ifdef PAD_SCAN_DEBOUNCE_EN
    prev_d  = prev_q;
`endif
    if (CE) begin
      case (state_q)
        IDLE: if (SCAN_REQ) begin
          state_d = STEP;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          th_d    = 1'b1;
          phase_d = 3'd0;
          cnt_d   = STEP_LD;
        end
        STEP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            samp_d[phase_q] = ~sync_q;
            if (phase_q != LAST_PH) begin
              phase_d = phase_q + 3'd1;
              th_d    = ~th_q;
              cnt_d   = STEP_LD;
            end else begin
              th_d    = 1'b1;
              cnt_d   = IDLE_LD;
              state_d = GAP;
              for (int n = 0; n < NUM_PADS; n++) begin
                if (idx_q == 3'(n)) begin
                  pres_d[n] = dec_pres;
                  six_d[n]  = dec_six;
`ifdef PAD_SCAN_DEBOUNCE_EN
                  if (dec_btn == prev_q[n]) btn_d[n] = dec_btn;
                  prev_d[n] = dec_btn;
`else
                  btn_d[n]  = dec_btn;
`endif
                end
              end
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (idx_q != LAST_PAD) begin
            idx_d   = idx_q + 3'd1;
            phase_d = 3'd0;
            cnt_d   = STEP_LD;
            state_d = STEP;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = 3'd0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      th_q    <= 1'b1;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 3'd0;
      samp_q  <= '0;
      btn_q   <= '0;
      pres_q  <= '0;
      six_q   <= '0;
`ifdef PAD_SCAN_DEBOUNCE_EN
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      th_q    <= th_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      samp_q  <= samp_d;
      btn_q   <= btn_d;
      pres_q  <= pres_d;
      six_q   <= six_d;
`ifdef PAD_SCAN_DEBOUNCE_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign PAD_TH  = th_q;
  assign PAD_IDX = idx_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BTN     = btn_q;
  assign PRESENT = pres_q;
  assign SIX_BTN = six_q;
endmodule
